decoder_sequencer: RTL and testbench
====================================

DECODER_SEQUENCER -- requirements
Module: decoder_sequencer

Interface
REQ-001 Parameter RESET_IR, default 8'h00; opcode value loaded into IR at reset and on interrupt-dispatch entry.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 nRESET  input  1  reset, synchronous, active-low; sampled on posedge CLK.
REQ-004 m_tick  input  1  one-CLK strobe marking the end of a machine cycle; state advances only on m_tick=1.
REQ-005 op_end  input  1  current M-cycle is the last of the current instruction; qualified by m_tick.
REQ-006 db  input  8  opcode byte on the data bus; captured into IR when a fetch completes.
REQ-007 int_pending  input  1  enabled interrupt request pending (IE & IF nonzero).
REQ-008 ime  input  1  interrupt master enable.
REQ-009 a  output  26  Decoder1 input vector (mapping REQ-013).
REQ-010 ir  output  8  current opcode register.
REQ-011 state  output  3  M-cycle index within current instruction.
REQ-012 cb_mode, intr_dispatch, halted, seq_err  output  1 each  CB-prefix mode; interrupt dispatch in progress; CPU halted; sticky state-overflow error.

Function
REQ-013 a SHALL be combinational from registers: a[1]=intr_dispatch, a[0]=~a[1]; a[3]=cb_mode, a[2]=~a[3]; for k=0..7 a[19-2k]=ir[k], a[18-2k]=~ir[k]; a[21]=state[2], a[23]=state[1], a[25]=state[0], a[20]/a[22]/a[24] their complements.
REQ-014 FSM SHALL have two states, RUN and HALTED; all register updates below occur only on a CLK edge with m_tick=1 and nRESET=1; m_tick=0 holds every register.
REQ-015 RUN, op_end=0: state SHALL increment by 1; at state=7 it SHALL hold 7 and set seq_err=1 (sticky until reset).
REQ-016 RUN, op_end=1, priority order (first match wins):
- (a) ir=8'hCB, cb_mode=0, intr_dispatch=0: cb_mode<=1, ir<=db, state<=0; interrupt NOT taken.
- (b) ir=8'h76, cb_mode=0, intr_dispatch=0: enter HALTED, state<=0, ir held, halted<=1.
- (c) int_pending=1 and ime=1: intr_dispatch<=1, cb_mode<=0, ir<=RESET_IR, state<=0.
- (d) otherwise: ir<=db, cb_mode<=0, intr_dispatch<=0, state<=0.
REQ-017 Rule (c) SHALL also apply when intr_dispatch=1 already (back-to-back dispatch); rule (d) clears intr_dispatch.
REQ-018 HALTED, int_pending=0: all registers held, op_end ignored, seq_err unaffected.
REQ-019 HALTED, int_pending=1: halted<=0, return to RUN, state<=0; if ime=1 intr_dispatch<=1, ir<=RESET_IR; else ir<=db, intr_dispatch<=0; cb_mode<=0 either way.
REQ-020 Latency: ir/state/cb_mode/intr_dispatch SHALL change on the same CLK edge that samples m_tick; a reflects them with zero additional cycles.
REQ-021 db, int_pending, ime SHALL be sampled only on qualifying m_tick edges; changes between ticks SHALL have no effect.
REQ-022 halted output SHALL equal 1 exactly when FSM is HALTED.

Reset
REQ-023 nRESET=0 at a posedge CLK SHALL, regardless of m_tick or FSM state (including mid-instruction and HALTED), set ir=RESET_IR, state=0, cb_mode=0, intr_dispatch=0, halted=0, seq_err=0, FSM=RUN.
REQ-024 With RESET_IR=8'h00, a SHALL equal 26'h1555555 in the cycle after reset.
REQ-025 First qualifying m_tick after reset release SHALL be processed per REQ-015/016 with no extra delay.

Verification
REQ-026 Reset: hold nRESET=0 two cycles with m_tick=1 -> ir=00, state=0, a=26'h1555555, all flags 0.
REQ-027 Plain fetch: ir=00, m_tick+op_end, db=8'h3E -> ir=3E, state=0; two m_tick without op_end -> state=2; a[19:4] bitwise matches ir/~ir pairs.
REQ-028 CB prefix vs interrupt: ir=CB, int_pending=1, ime=1, m_tick+op_end, db=8'h37 -> cb_mode=1, ir=37, intr_dispatch=0; next op_end with db=00 -> intr_dispatch=1, cb_mode=0, ir=00.
REQ-029 HALT: ir=76, op_end tick -> halted=1; 5 ticks with int_pending=0 -> state and ir unchanged; int_pending=1, ime=0, db=8'h04 on tick -> halted=0, ir=04, intr_dispatch=0.
REQ-030 Overflow: 9 m_tick with op_end=0 from state=0 -> state=7, seq_err=1; subsequent op_end clears state to 0, seq_err stays 1 until reset.
REQ-031 Reset mid-HALTED and mid-dispatch: assert nRESET=0 -> REQ-023 values on next edge; m_tick=0 cycles throughout -> no register change.

Source files
------------

// File: rtl/decoder_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decoder_sequencer: opcode register, M-cycle sequencer, CB/HALT/interrupt  |
// | control, and the Decoder1 one-hot-pair input vector.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module decoder_sequencer #(
  parameter logic [7:0] RESET_IR = 8'h00
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        m_tick,
  input  logic        op_end,
  input  logic [7:0]  db,
  input  logic        int_pending,
  input  logic        ime,
  output logic [25:0] a,
  output logic [7:0]  ir,
  output logic [2:0]  state,
  output logic        cb_mode,
  output logic        intr_dispatch,
  output logic        halted,
  output logic        seq_err
);

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} fsm_t;

  localparam logic [7:0] C_OP_CB   = 8'hCB;
  localparam logic [7:0] C_OP_HALT = 8'h76;

  fsm_t       r_fsm,  w_fsm_nxt;
  logic [7:0] r_ir,   w_ir_nxt;
  logic [2:0] r_state, w_state_nxt;
  logic       r_cb,   w_cb_nxt;
  logic       r_intr, w_intr_nxt;
  logic       r_err,  w_err_nxt;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_fsm   <= RUN;
      r_ir    <= RESET_IR;
      r_state <= 3'd0;
      r_cb    <= 1'b0;
      r_intr  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_ir    <= w_ir_nxt;
      r_state <= w_state_nxt;
      r_cb    <= w_cb_nxt;
      r_intr  <= w_intr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_ir_nxt    = r_ir;
    w_state_nxt = r_state;
    w_cb_nxt    = r_cb;
    w_intr_nxt  = r_intr;
    w_err_nxt   = r_err;
    if (m_tick) begin
      case (r_fsm)
        RUN: begin
          if (!op_end) begin
            // Saturate at the last index and flag that the instruction overran.
            if (r_state == 3'd7) w_err_nxt   = 1'b1;
            else                 w_state_nxt = r_state + 3'd1;
          end else begin
            w_state_nxt = 3'd0;
            // CB prefix and HALT only count as plain opcodes, never as a
            // CB-table opcode or the dispatch pseudo-opcode.
            if (r_ir == C_OP_CB && !r_cb && !r_intr) begin
              w_cb_nxt = 1'b1;
              w_ir_nxt = db;
            end else if (r_ir == C_OP_HALT && !r_cb && !r_intr) begin
              w_fsm_nxt = HALTED;
            end else if (int_pending && ime) begin
              w_intr_nxt = 1'b1;
              w_cb_nxt   = 1'b0;
              w_ir_nxt   = RESET_IR;
            end else begin
              w_ir_nxt   = db;
              w_cb_nxt   = 1'b0;
              w_intr_nxt = 1'b0;
            end
          end
        end
        HALTED: begin
          if (int_pending) begin
            w_fsm_nxt   = RUN;
            w_state_nxt = 3'd0;
            w_cb_nxt    = 1'b0;
            w_intr_nxt  = ime;
            w_ir_nxt    = ime ? RESET_IR : db;
          end
        end
        default: w_fsm_nxt = RUN;
      endcase
    end
  end

  assign ir            = r_ir;
  assign state         = r_state;
  assign cb_mode       = r_cb;
  assign intr_dispatch = r_intr;
  assign halted        = (r_fsm == HALTED);
  assign seq_err       = r_err;

  assign a[1]  = r_intr;
  assign a[0]  = ~r_intr;
  assign a[3]  = r_cb;
  assign a[2]  = ~r_cb;
  assign a[21] = r_state[2];
  assign a[20] = ~r_state[2];
  assign a[23] = r_state[1];
  assign a[22] = ~r_state[1];
  assign a[25] = r_state[0];
  assign a[24] = ~r_state[0];

  generate
    for (genvar k = 0; k < 8; k++) begin : g_ir_pairs
      assign a[19-2*k] = r_ir[k];
      assign a[18-2*k] = ~r_ir[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decoder_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decoder_sequencer: directed vector table plus multi-cycle sequences.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_decoder_sequencer;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        m_tick, op_end, int_pending, ime;
  logic [7:0]  db;
  logic [25:0] a;
  logic [7:0]  ir;
  logic [2:0]  state;
  logic        cb_mode, intr_dispatch, halted, seq_err;

  int checks = 0;
  int errors = 0;

  decoder_sequencer #(.RESET_IR(8'h00)) dut (
    .CLK(CLK), .nRESET(nRESET), .m_tick(m_tick), .op_end(op_end), .db(db),
    .int_pending(int_pending), .ime(ime), .a(a), .ir(ir), .state(state),
    .cb_mode(cb_mode), .intr_dispatch(intr_dispatch), .halted(halted),
    .seq_err(seq_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       tick, ope;
    logic [7:0] db;
    logic       ip, ie;
    logic [7:0] ir;
    logic [2:0] st;
    logic       cb, intr, hlt, err;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic tick, logic ope, logic [7:0] d, logic ip, logic ie,
                              logic [7:0] eir, logic [2:0] est, logic ecb, logic eintr,
                              logic ehlt, logic eerr);
    vec_t v;
    v.tick = tick; v.ope = ope; v.db = d; v.ip = ip; v.ie = ie;
    v.ir = eir; v.st = est; v.cb = ecb; v.intr = eintr; v.hlt = ehlt; v.err = eerr;
    return v;
  endfunction

  function automatic logic [25:0] exp_a(logic [7:0] eir, logic [2:0] est, logic ecb, logic eintr);
    logic [25:0] v;
    v[1] = eintr;  v[0] = ~eintr;
    v[3] = ecb;    v[2] = ~ecb;
    for (int k = 0; k < 8; k++) begin
      v[19-2*k] = eir[k];
      v[18-2*k] = ~eir[k];
    end
    v[21] = est[2]; v[20] = ~est[2];
    v[23] = est[1]; v[22] = ~est[1];
    v[25] = est[0]; v[24] = ~est[0];
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [7:0] eir, logic [2:0] est, logic ecb,
                           logic eintr, logic ehlt, logic eerr);
    check({tag, ".ir"},    {24'd0, ir}, {24'd0, eir});
    check({tag, ".state"}, {29'd0, state}, {29'd0, est});
    check({tag, ".cb"},    {31'd0, cb_mode}, {31'd0, ecb});
    check({tag, ".intr"},  {31'd0, intr_dispatch}, {31'd0, eintr});
    check({tag, ".halt"},  {31'd0, halted}, {31'd0, ehlt});
    check({tag, ".err"},   {31'd0, seq_err}, {31'd0, eerr});
    check({tag, ".a"},     {6'd0, a}, {6'd0, exp_a(eir, est, ecb, eintr)});
  endtask

  task automatic step(logic tick, logic ope, logic [7:0] d, logic ip, logic ie);
    m_tick = tick; op_end = ope; db = d; int_pending = ip; ime = ie;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1);
    nRESET = 1'b1;
  endtask

  initial begin
    // After reset: ir=00 state=0, all flags clear.
    vecs[0]  = mk(1,1,8'h3E,0,0, 8'h3E,3'd0,0,0,0,0); // plain fetch
    vecs[1]  = mk(1,0,8'hFF,0,0, 8'h3E,3'd1,0,0,0,0);
    vecs[2]  = mk(1,0,8'hFF,0,0, 8'h3E,3'd2,0,0,0,0);
    vecs[3]  = mk(0,1,8'hFF,1,1, 8'h3E,3'd2,0,0,0,0); // no tick: hold
    vecs[4]  = mk(1,1,8'hCB,0,0, 8'hCB,3'd0,0,0,0,0);
    vecs[5]  = mk(1,1,8'h37,1,1, 8'h37,3'd0,1,0,0,0); // CB beats interrupt
    vecs[6]  = mk(1,1,8'h00,1,1, 8'h00,3'd0,0,1,0,0); // dispatch
    vecs[7]  = mk(1,1,8'h55,1,1, 8'h00,3'd0,0,1,0,0); // back-to-back dispatch
    vecs[8]  = mk(1,1,8'h76,0,0, 8'h76,3'd0,0,0,0,0);
    vecs[9]  = mk(1,1,8'h11,0,0, 8'h76,3'd0,0,0,1,0); // enter HALT
    vecs[10] = mk(1,1,8'h22,0,1, 8'h76,3'd0,0,0,1,0);
    vecs[11] = mk(1,0,8'h33,0,1, 8'h76,3'd0,0,0,1,0);
    vecs[12] = mk(1,0,8'h04,1,0, 8'h04,3'd0,0,0,0,0); // wake, ime=0
    vecs[13] = mk(1,1,8'h76,0,0, 8'h76,3'd0,0,0,0,0);
    vecs[14] = mk(1,1,8'h00,0,0, 8'h76,3'd0,0,0,1,0);
    vecs[15] = mk(1,0,8'h99,1,1, 8'h00,3'd0,0,1,0,0); // wake, ime=1
    vecs[16] = mk(1,1,8'hCB,0,0, 8'hCB,3'd0,0,0,0,0); // ir00 under dispatch -> (d)
    vecs[17] = mk(1,1,8'h76,0,0, 8'h76,3'd0,1,0,0,0); // CB prefix, 76 is a CB op
    vecs[18] = mk(1,1,8'h10,0,0, 8'h10,3'd0,0,0,0,0); // CB 76 does not halt

    nRESET = 1'b0; m_tick = 0; op_end = 0; db = 0; int_pending = 0; ime = 0;

    do_reset();
    check_all("reset", 8'h00, 3'd0, 0, 0, 0, 0);
    check("reset.a_const", {6'd0, a}, {6'd0, 26'h1555555});

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].tick, vecs[i].ope, vecs[i].db, vecs[i].ip, vecs[i].ie);
      check_all($sformatf("vec%0d", i), vecs[i].ir, vecs[i].st, vecs[i].cb,
                vecs[i].intr, vecs[i].hlt, vecs[i].err);
    end

    // Overflow: 9 ticks without op_end saturate at 7 and set the sticky error.
    for (int i = 0; i < 9; i++) step(1, 0, 8'hEE, 1, 1);
    check_all("ovf", 8'h10, 3'd7, 0, 0, 0, 1);
    step(1, 1, 8'h21, 0, 0);
    check_all("ovf_end", 8'h21, 3'd0, 0, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0);
    check_all("ovf_sticky", 8'h21, 3'd1, 0, 0, 0, 1);

    // Reset while HALTED.
    step(1, 1, 8'h76, 0, 0);
    step(1, 1, 8'h00, 0, 0);
    check_all("pre_rst_halt", 8'h76, 3'd0, 0, 0, 1, 1);
    nRESET = 1'b0;
    step(1, 1, 8'h33, 1, 1);
    nRESET = 1'b1;
    check_all("rst_halt", 8'h00, 3'd0, 0, 0, 0, 0);

    // Reset mid-dispatch, mid-instruction, with m_tick low.
    step(1, 1, 8'h00, 1, 1);
    step(1, 0, 8'h00, 0, 0);
    check_all("pre_rst_intr", 8'h00, 3'd1, 0, 1, 0, 0);
    nRESET = 1'b0;
    step(0, 0, 8'h44, 0, 0);
    nRESET = 1'b1;
    check_all("rst_intr", 8'h00, 3'd0, 0, 0, 0, 0);

    // First tick after release processed immediately; idle cycles change nothing.
    step(1, 1, 8'hCB, 0, 0);
    check_all("post_rst", 8'hCB, 3'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(i * 37 + 5), 1, 1);
    check_all("idle_hold", 8'hCB, 3'd0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
